// File: rtl/cpsr_flagunit_pkg.sv
// rtl/cpsr_flagunit_pkg.sv - flag-vector layout and update-action decode shared by the CPSR flag unit.
package cpsr_flagunit_pkg;

    // Flag vector layout, shared with the condition checker: {N, Z, C, V}.
    localparam int FLAGSW = 4;
    localparam int N_I    = 3;
    localparam int Z_I    = 2;
    localparam int C_I    = 1;
    localparam int V_I    = 0;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    // What the flag registers do on the next edge, reset aside.
    typedef enum logic [1:0] {
        ACT_HOLD    = 2'd0,
        ACT_MSR     = 2'd1,
        ACT_FLUSH   = 2'd2,
        ACT_ADVANCE = 2'd3
    } flag_action_e;

    // Stall freezes everything; a direct MSR write beats a flush, which beats normal advance.
    function automatic flag_action_e decode_action(input logic stall,
                                                   input logic msr_write,
                                                   input logic flush);
        flag_action_e act;
        if (stall) begin
            act = ACT_HOLD;
        end else if (msr_write) begin
            act = ACT_MSR;
        end else if (flush) begin
            act = ACT_FLUSH;
        end else begin
            act = ACT_ADVANCE;
        end
        return act;
    endfunction

endpackage

// File: rtl/cpsr_flagunit_flag_compute.sv
// rtl/cpsr_flagunit_flag_compute.sv - combinational NZCV from an ALU result, carry/overflow and the prior V.
module cpsr_flagunit_flag_compute
    import cpsr_flagunit_pkg::*;
#(
    parameter int DATAW = 32
) (
    input  logic [DATAW-1:0]  i_result,
    input  logic              i_carry,
    input  logic              i_overflow,
    input  logic              i_shift_carry,
    input  logic              i_arith,
    input  logic              i_prior_v,
    output logic [FLAGSW-1:0] o_flags
);

    nzcv_t w_flags;

    // Logical ops take C from the shifter and leave V untouched.
    always_comb begin
        w_flags   = '0;
        w_flags.n = i_result[DATAW-1];
        w_flags.z = (i_result == '0);
        w_flags.c = i_arith ? i_carry    : i_shift_carry;
        w_flags.v = i_arith ? i_overflow : i_prior_v;
    end

    assign o_flags = w_flags;

endmodule

// File: rtl/cpsr_flagunit.sv
// rtl/cpsr_flagunit.sv - CPSR flag producer: pending (execute) and architectural (writeback) NZCV registers.
// Optional FLAG_FORWARD_EN: forward the pending flags to cpsrout instead of raising flagbusyout.
module cpsr_flagunit
    import cpsr_flagunit_pkg::*;
#(
    parameter int                DATAW     = 32,
    parameter logic [FLAGSW-1:0] RESETNZCV = 4'b0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATAW-1:0]  aluresultin,
    input  logic              alucarryin,
    input  logic              aluoverflowin,
    input  logic              shiftcarryin,
    input  logic              arithin,
    input  logic              setflagsin,
    input  logic              validin,
    input  logic              shouldexecin,
    input  logic              msrwritein,
    input  logic [FLAGSW-1:0] msrdatain,
    input  logic              stallin,
    input  logic              flushin,
    output logic [FLAGSW-1:0] cpsrout,
    output logic              flagbusyout
);

    logic [FLAGSW-1:0] r_arch;
    logic [FLAGSW-1:0] r_pend;
    logic              r_pend_valid;

    logic              w_upd;
    logic              w_prior_v;
    logic [FLAGSW-1:0] w_computed;
    flag_action_e      w_action;

    assign w_upd    = validin & shouldexecin & setflagsin & ~stallin;
    assign w_action = decode_action(stallin, msrwritein, flushin);

    // A logical op must see the newest V, which may still be sitting in the pending register.
    assign w_prior_v = r_pend_valid ? r_pend[V_I] : r_arch[V_I];

    cpsr_flagunit_flag_compute #(
        .DATAW (DATAW)
    ) u_flag_compute (
        .i_result      (aluresultin),
        .i_carry       (alucarryin),
        .i_overflow    (aluoverflowin),
        .i_shift_carry (shiftcarryin),
        .i_arith       (arithin),
        .i_prior_v     (w_prior_v),
        .o_flags       (w_computed)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_arch       <= RESETNZCV;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
        end else begin
            case (w_action)
                ACT_MSR: begin
                    r_arch       <= msrdatain;
                    r_pend_valid <= 1'b0;
                end
                ACT_FLUSH: begin
                    r_pend_valid <= 1'b0;
                end
                ACT_ADVANCE: begin
                    // Back-to-back updates retire the old pending value while capturing the new one.
                    if (r_pend_valid) begin
                        r_arch <= r_pend;
                    end
                    if (w_upd) begin
                        r_pend <= w_computed;
                    end
                    r_pend_valid <= w_upd;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FLAG_FORWARD_EN
    assign cpsrout     = r_pend_valid ? r_pend : r_arch;
    assign flagbusyout = 1'b0;
`else
    assign cpsrout     = r_arch;
    assign flagbusyout = r_pend_valid;
`endif

endmodule

// File: tb/tb_cpsr_flagunit.sv
// tb/tb_cpsr_flagunit.sv - scoreboard bench for cpsr_flagunit: directed scenarios plus randomized traffic.
module tb_cpsr_flagunit;

    localparam logic [3:0] RESETNZCV = 4'b0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] aluresultin;
    logic        alucarryin;
    logic        aluoverflowin;
    logic        shiftcarryin;
    logic        arithin;
    logic        setflagsin;
    logic        validin;
    logic        shouldexecin;
    logic        msrwritein;
    logic [3:0]  msrdatain;
    logic        stallin;
    logic        flushin;
    logic [3:0]  cpsrout;
    logic        flagbusyout;

    int checks   = 0;
    int failures = 0;

    logic [3:0] m_arch = RESETNZCV;
    logic [3:0] m_pend[$];
    logic [4:0] exp_q[$];

    cpsr_flagunit #(
        .DATAW     (32),
        .RESETNZCV (RESETNZCV)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .aluresultin   (aluresultin),
        .alucarryin    (alucarryin),
        .aluoverflowin (aluoverflowin),
        .shiftcarryin  (shiftcarryin),
        .arithin       (arithin),
        .setflagsin    (setflagsin),
        .validin       (validin),
        .shouldexecin  (shouldexecin),
        .msrwritein    (msrwritein),
        .msrdatain     (msrdatain),
        .stallin       (stallin),
        .flushin       (flushin),
        .cpsrout       (cpsrout),
        .flagbusyout   (flagbusyout)
    );

    always #5 clk = ~clk;

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [3:0] ref_flags(input logic [31:0] res, input logic c, input logic v,
                                             input logic sc, input logic ar, input logic prior_v);
        logic n, z, cc, vv;
        n  = (res >= 32'h8000_0000);
        z  = (res == 32'd0);
        cc = ar ? c : sc;
        vv = ar ? v : prior_v;
        return {n, z, cc, vv};
    endfunction

    // Reference model: a queue of uncommitted flag values feeding the architectural value.
    initial forever begin
        logic       upd;
        logic       newest_v;
        logic [3:0] comp;
        logic [3:0] tail;
        logic [3:0] exp_cpsr;
        logic       exp_busy;
        @(posedge clk);
        if (reset) begin
            m_arch = RESETNZCV;
            m_pend.delete();
        end else if (!stallin) begin
            if (msrwritein) begin
                m_arch = msrdatain;
                m_pend.delete();
            end else if (flushin) begin
                m_pend.delete();
            end else begin
                if (m_pend.size() != 0) begin
                    tail     = m_pend[m_pend.size()-1];
                    newest_v = tail[0];
                end else begin
                    newest_v = m_arch[0];
                end
                upd  = validin && shouldexecin && setflagsin;
                comp = ref_flags(aluresultin, alucarryin, aluoverflowin, shiftcarryin, arithin, newest_v);
                if (m_pend.size() != 0) m_arch = m_pend.pop_front();
                if (upd) m_pend.push_back(comp);
            end
        end
`ifdef FLAG_FORWARD_EN
        exp_cpsr = (m_pend.size() != 0) ? m_pend[0] : m_arch;
        exp_busy = 1'b0;
`else
        exp_cpsr = m_arch;
        exp_busy = (m_pend.size() != 0);
`endif
        exp_q.push_back({exp_busy, exp_cpsr});
    end

    initial forever begin
        logic [4:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check4("sb_underflow", 4'd1, 4'd0);
        end else begin
            e = exp_q.pop_front();
            check4("sb_cpsrout", cpsrout, e[3:0]);
            check4("sb_busy", {3'b000, flagbusyout}, {3'b000, e[4]});
        end
    end

    task automatic idle();
        reset         = 1'b0;
        aluresultin   = '0;
        alucarryin    = 1'b0;
        aluoverflowin = 1'b0;
        shiftcarryin  = 1'b0;
        arithin       = 1'b0;
        setflagsin    = 1'b0;
        validin       = 1'b0;
        shouldexecin  = 1'b1;
        msrwritein    = 1'b0;
        msrdatain     = '0;
        stallin       = 1'b0;
        flushin       = 1'b0;
    endtask

    task automatic alu(input logic [31:0] res, input logic c, input logic v,
                       input logic sc, input logic ar);
        idle();
        validin       = 1'b1;
        setflagsin    = 1'b1;
        aluresultin   = res;
        alucarryin    = c;
        aluoverflowin = v;
        shiftcarryin  = sc;
        arithin       = ar;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic random_cycle();
        int sel;
        idle();
        reset         = ($urandom_range(0, 99) < 2);
        stallin       = ($urandom_range(0, 99) < 20);
        flushin       = ($urandom_range(0, 99) < 10);
        msrwritein    = ($urandom_range(0, 99) < 8);
        msrdatain     = 4'($urandom);
        validin       = ($urandom_range(0, 99) < 85);
        shouldexecin  = ($urandom_range(0, 99) < 80);
        setflagsin    = ($urandom_range(0, 99) < 75);
        alucarryin    = 1'($urandom);
        aluoverflowin = 1'($urandom);
        shiftcarryin  = 1'($urandom);
        arithin       = 1'($urandom);
        sel           = $urandom_range(0, 3);
        case (sel)
            0:       aluresultin = 32'd0;
            1:       aluresultin = 32'h8000_0000 | 32'($urandom);
            default: aluresultin = 32'($urandom);
        endcase
    endtask

    initial begin
        idle();
        reset = 1'b1;
        repeat (3) tick();
        check4("reset_cpsr", cpsrout, RESETNZCV);
        check4("reset_busy", {3'b000, flagbusyout}, 4'b0000);

        // SUBS giving zero with carry out
        alu(32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
`ifdef FLAG_FORWARD_EN
        check4("subs_fwd_visible", cpsrout, 4'b0110);
`else
        check4("subs_busy_one_cycle", {3'b000, flagbusyout}, 4'b0001);
`endif
        idle();
        tick();
        check4("subs_nzcv", cpsrout, 4'b0110);
        check4("subs_busy_cleared", {3'b000, flagbusyout}, 4'b0000);

        // ADDS setting V, then ANDS that must keep it
        alu(32'd1, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        alu(32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        check4("ands_v_kept", cpsrout, 4'b1011);

        // Back-to-back ADDS then SUBS
        alu(32'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        alu(32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
`ifdef FLAG_FORWARD_EN
        check4("b2b_second_fwd", cpsrout, 4'b1000);
`else
        check4("b2b_first_commit", cpsrout, 4'b0000);
`endif
        idle();
        tick();
        check4("b2b_second_commit", cpsrout, 4'b1000);

        // Update held across a 3-cycle stall, flush during stall ignored
        alu(32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        stallin = 1'b1;
        tick();
        tick();
        flushin = 1'b1;
        tick();
        idle();
        tick();
        check4("stall_then_commit", cpsrout, 4'b0100);

        // Flush kills pending; unexecuted or non-S ops never update
        alu(32'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        flushin = 1'b1;
        tick();
        idle();
        tick();
        check4("flush_kills_pend", cpsrout, 4'b0100);
        check4("flush_busy_low", {3'b000, flagbusyout}, 4'b0000);
        alu(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
        shouldexecin = 1'b0;
        tick();
        alu(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
        setflagsin = 1'b0;
        tick();
        idle();
        tick();
        check4("no_exec_no_update", cpsrout, 4'b0100);

        // MSR overrides an outstanding pending commit
        alu(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        msrwritein = 1'b1;
        msrdatain  = 4'b1111;
        alu(32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        msrwritein = 1'b1;
        msrdatain  = 4'b1111;
        tick();
        idle();
        tick();
        check4("msr_wins", cpsrout, 4'b1111);

        // Reset beats MSR, pending and stall
        alu(32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        msrwritein = 1'b1;
        msrdatain  = 4'b1010;
        stallin    = 1'b1;
        reset      = 1'b1;
        tick();
        idle();
        tick();
        check4("reset_mid_cpsr", cpsrout, RESETNZCV);
        check4("reset_mid_busy", {3'b000, flagbusyout}, 4'b0000);

        repeat (3000) begin
            random_cycle();
            tick();
        end
        idle();
        repeat (3) tick();
        check4("sb_drained", 4'(exp_q.size()), 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
